// File: rtl/mips_pkg.sv
// Opcode constants and FSM state type shared by the memory stage.
// Byte-access opcodes are only decoded as memory ops under MEM_STAGE_BYTE_ACCESS_EN.
package mips_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_LB    = 6'b100000;
   localparam logic [5:0] OP_LBU   = 6'b100100;
   localparam logic [5:0] OP_SB    = 6'b101000;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      RESP = 2'd2
   } mem_state_e;

endpackage

// File: rtl/mem_stage_if.sv
// Execute-result input, data-memory bus and writeback bundle of the memory stage.
interface mem_stage_if;

   logic        in_valid;
   logic        in_ready;
   logic [5:0]  opcode;
   logic [31:0] alu_result;
   logic [31:0] store_data;
   logic [4:0]  dest_reg;
   logic        reg_write;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   logic        wb_valid;
   logic [31:0] wb_data;
   logic [4:0]  wb_reg;
   logic        wb_we;
   logic        exc_misaligned;
   logic        exc_bus;

   modport slave (
      input  in_valid, opcode, alu_result, store_data,
      input  dest_reg, reg_write, mem_ack, mem_rdata,
      output in_ready, mem_req, mem_we, mem_addr, mem_be,
      output mem_wdata, wb_valid, wb_data, wb_reg, wb_we,
      output exc_misaligned, exc_bus
   );

   modport master (
      output in_valid, opcode, alu_result, store_data,
      output dest_reg, reg_write, mem_ack, mem_rdata,
      input  in_ready, mem_req, mem_we, mem_addr, mem_be,
      input  mem_wdata, wb_valid, wb_data, wb_reg, wb_we,
      input  exc_misaligned, exc_bus
   );

endinterface

// File: rtl/mem_load_align.sv
// Selects the addressed byte of a read word and sign/zero-extends it for LB/LBU.
module mem_load_align
   import mips_pkg::*;
(
   input  logic [5:0]  opcode_i,
   input  logic [1:0]  off_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [7:0] byte_sel;

   // little-endian lanes: offset 0 is bits 7:0
   always_comb begin
      byte_sel = rdata_i[7:0];
      unique case (off_i)
         2'd0: byte_sel = rdata_i[7:0];
         2'd1: byte_sel = rdata_i[15:8];
         2'd2: byte_sel = rdata_i[23:16];
         2'd3: byte_sel = rdata_i[31:24];
      endcase
   end

   always_comb begin
      data_o = rdata_i;
      if (opcode_i == OP_LB)
         data_o = {{24{byte_sel[7]}}, byte_sel};
      else if (opcode_i == OP_LBU)
         data_o = {24'h0, byte_sel};
   end

endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: issues loads/stores on a req/ack bus with a bus timeout.
// Define MEM_STAGE_BYTE_ACCESS_EN to add LB/LBU/SB byte accesses.
module mem_stage
   import mips_pkg::*;
#(
   parameter int TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   mem_stage_if.slave bus
);

   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   mem_state_e    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ld_q, ld_d;
   logic          rw_q, rw_d;
   logic          berr_q, berr_d;
   logic [5:0]    op_q, op_d;
   logic [1:0]    off_q, off_d;
   logic [31:0]   rdata_q, rdata_d;

   logic          mem_req_q, mem_req_d;
   logic          mem_we_q, mem_we_d;
   logic [31:0]   mem_addr_q, mem_addr_d;
   logic [3:0]    mem_be_q, mem_be_d;
   logic [31:0]   mem_wdata_q, mem_wdata_d;
   logic          wb_valid_q, wb_valid_d;
   logic [31:0]   wb_data_q, wb_data_d;
   logic [4:0]    wb_reg_q, wb_reg_d;
   logic          wb_we_q, wb_we_d;
   logic          xmis_q, xmis_d;
   logic          xbus_q, xbus_d;

   logic          op_ld;
   logic          op_st;
   logic          op_nowr;
   logic          chk_al;
   logic          byte_op;
   logic          misal;
   logic [31:0]   ld_data;

   always_comb begin
      op_ld   = 1'b0;
      op_st   = 1'b0;
      op_nowr = 1'b0;
      chk_al  = 1'b1;
      unique case (bus.opcode)
         OP_LW: op_ld = 1'b1;
         OP_SW: op_st = 1'b1;
`ifdef MEM_STAGE_BYTE_ACCESS_EN
         OP_LB, OP_LBU: begin
            op_ld  = 1'b1;
            chk_al = 1'b0;
         end
         OP_SB: begin
            op_st  = 1'b1;
            chk_al = 1'b0;
         end
`else
         // byte opcodes pass through as ALU ops that never write back
         OP_LB, OP_LBU, OP_SB: op_nowr = 1'b1;
`endif
         default: ;
      endcase
   end

   assign byte_op = ~chk_al;
   assign misal   = chk_al & (bus.alu_result[1:0] != 2'b00);

   mem_load_align u_align (
      .opcode_i (op_q),
      .off_i    (off_q),
      .rdata_i  (rdata_q),
      .data_o   (ld_data)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      ld_d        = ld_q;
      rw_d        = rw_q;
      berr_d      = berr_q;
      op_d        = op_q;
      off_d       = off_q;
      rdata_d     = rdata_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_be_d    = mem_be_q;
      mem_wdata_d = mem_wdata_q;
      wb_valid_d  = 1'b0;
      wb_data_d   = wb_data_q;
      wb_reg_d    = wb_reg_q;
      wb_we_d     = 1'b0;
      xmis_d      = 1'b0;
      xbus_d      = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               wb_reg_d = bus.dest_reg;
               if ((op_ld || op_st) && misal) begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = '0;
                  xmis_d     = 1'b1;
               end else if (op_ld || op_st) begin
                  state_d     = REQ;
                  cnt_d       = '0;
                  ld_d        = op_ld;
                  rw_d        = bus.reg_write;
                  berr_d      = 1'b0;
                  op_d        = bus.opcode;
                  off_d       = bus.alu_result[1:0];
                  mem_req_d   = 1'b1;
                  mem_we_d    = op_st;
                  mem_addr_d  = {bus.alu_result[31:2], 2'b00};
                  mem_be_d    = (byte_op && op_st) ?
                                (4'b0001 << bus.alu_result[1:0]) :
                                4'b1111;
                  mem_wdata_d = byte_op ?
                                {4{bus.store_data[7:0]}} :
                                bus.store_data;
               end else begin
                  wb_valid_d = 1'b1;
                  wb_data_d  = bus.alu_result;
                  wb_we_d    = bus.reg_write & ~op_nowr;
               end
            end
         end
         REQ: begin
            // ack beats the timeout when both land in the same cycle
            if (bus.mem_ack) begin
               state_d   = RESP;
               rdata_d   = bus.mem_rdata;
               berr_d    = 1'b0;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_be_d  = 4'b0000;
            end else if (cnt_q == CNT_LAST) begin
               state_d   = RESP;
               berr_d    = 1'b1;
               mem_req_d = 1'b0;
               mem_we_d  = 1'b0;
               mem_be_d  = 4'b0000;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RESP: begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            xbus_d     = berr_q;
            wb_we_d    = ld_q & rw_q & ~berr_q;
            wb_data_d  = (ld_q && !berr_q) ? ld_data : '0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         ld_q        <= 1'b0;
         rw_q        <= 1'b0;
         berr_q      <= 1'b0;
         op_q        <= '0;
         off_q       <= '0;
         rdata_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_be_q    <= '0;
         mem_wdata_q <= '0;
         wb_valid_q  <= 1'b0;
         wb_data_q   <= '0;
         wb_reg_q    <= '0;
         wb_we_q     <= 1'b0;
         xmis_q      <= 1'b0;
         xbus_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         ld_q        <= ld_d;
         rw_q        <= rw_d;
         berr_q      <= berr_d;
         op_q        <= op_d;
         off_q       <= off_d;
         rdata_q     <= rdata_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_be_q    <= mem_be_d;
         mem_wdata_q <= mem_wdata_d;
         wb_valid_q  <= wb_valid_d;
         wb_data_q   <= wb_data_d;
         wb_reg_q    <= wb_reg_d;
         wb_we_q     <= wb_we_d;
         xmis_q      <= xmis_d;
         xbus_q      <= xbus_d;
      end
   end

   assign bus.in_ready       = (state_q == IDLE);
   assign bus.mem_req        = mem_req_q;
   assign bus.mem_we         = mem_we_q;
   assign bus.mem_addr       = mem_addr_q;
   assign bus.mem_be         = mem_be_q;
   assign bus.mem_wdata      = mem_wdata_q;
   assign bus.wb_valid       = wb_valid_q;
   assign bus.wb_data        = wb_data_q;
   assign bus.wb_reg         = wb_reg_q;
   assign bus.wb_we          = wb_we_q;
   assign bus.exc_misaligned = xmis_q;
   assign bus.exc_bus        = xbus_q;

endmodule

// File: tb/tb_mem_stage.sv
// Vector table plus scoreboard bench for mem_stage with TIMEOUT=4.
module tb_mem_stage;
   import mips_pkg::*;

   localparam int TMO = 4;

   typedef struct {
      logic [5:0]  op;
      logic [31:0] alu;
      logic [31:0] sd;
      logic [4:0]  dest;
      logic        rw;
      logic        mem;
      int          d;
      logic [31:0] rdata;
      logic [3:0]  be;
      logic        mwe;
      logic [31:0] mwd;
      logic [31:0] xd;
      logic        xchk;
      logic        xwe;
      logic        xmis;
      logic        xbus;
   } vec_t;

   typedef struct {
      int          cyc;
      logic [31:0] data;
      logic        chk;
      logic [4:0]  rg;
      logic        we;
      logic        mis;
      logic        bus;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   total;
   int   bad;
   exp_t q[$];
   vec_t vt[14];

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT(TMO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] a,
                      input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %h want %h (cycle %0d)", nm, a, e, cyc);
      end
   endtask

   function automatic vec_t mk(
      input logic [5:0] op, input logic [31:0] alu, input logic [31:0] sd,
      input logic [4:0] dest, input logic rw, input logic mem, input int d,
      input logic [31:0] rdata, input logic [3:0] be, input logic mwe,
      input logic [31:0] mwd, input logic [31:0] xd, input logic xchk,
      input logic xwe, input logic xmis, input logic xbus);
      vec_t v;
      v.op = op; v.alu = alu; v.sd = sd; v.dest = dest; v.rw = rw;
      v.mem = mem; v.d = d; v.rdata = rdata; v.be = be; v.mwe = mwe;
      v.mwd = mwd; v.xd = xd; v.xchk = xchk; v.xwe = xwe;
      v.xmis = xmis; v.xbus = xbus;
      return v;
   endfunction

   // scoreboard: every writeback pulse must match the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (bus.wb_valid) begin
         if (q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wb: wb_valid=1 want 0 (cycle %0d)", cyc);
         end else begin
            e = q.pop_front();
            chk("wb_cycle", 32'(cyc), 32'(e.cyc));
            chk("wb_reg", 32'(bus.wb_reg), 32'(e.rg));
            chk("wb_we", 32'(bus.wb_we), 32'(e.we));
            chk("exc_misaligned", 32'(bus.exc_misaligned), 32'(e.mis));
            chk("exc_bus", 32'(bus.exc_bus), 32'(e.bus));
            if (e.chk) chk("wb_data", bus.wb_data, e.data);
         end
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      exp_t e;
      int   n0;
      int   r;
      @(posedge clk); #1;
      chk($sformatf("in_ready_idle[%0d]", idx), 32'(bus.in_ready), 32'd1);
      bus.in_valid   = 1'b1;
      bus.opcode     = v.op;
      bus.alu_result = v.alu;
      bus.store_data = v.sd;
      bus.dest_reg   = v.dest;
      bus.reg_write  = v.rw;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      n0 = cyc;
      r  = v.mem ? ((v.d == 0) ? TMO : v.d) : 0;
      e.cyc  = n0 + (v.mem ? r + 1 : 0);
      e.data = v.xd;
      e.chk  = v.xchk;
      e.rg   = v.dest;
      e.we   = v.xwe;
      e.mis  = v.xmis;
      e.bus  = v.xbus;
      q.push_back(e);
      for (int k = 0; k < r; k++) begin
         if (v.d != 0 && k == r - 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rdata;
         end
         @(negedge clk);
         chk($sformatf("mem_req[%0d]", idx), 32'(bus.mem_req), 32'd1);
         chk($sformatf("mem_addr[%0d]", idx), bus.mem_addr,
             {v.alu[31:2], 2'b00});
         chk($sformatf("mem_be[%0d]", idx), 32'(bus.mem_be), 32'(v.be));
         chk($sformatf("mem_we[%0d]", idx), 32'(bus.mem_we), 32'(v.mwe));
         if (v.mwe)
            chk($sformatf("mem_wdata[%0d]", idx), bus.mem_wdata, v.mwd);
         chk($sformatf("in_ready_busy[%0d]", idx), 32'(bus.in_ready), 32'd0);
         @(posedge clk); #1;
         bus.mem_ack   = 1'b0;
         bus.mem_rdata = $urandom;
      end
      @(negedge clk);
      chk($sformatf("mem_req_off[%0d]", idx), 32'(bus.mem_req), 32'd0);
      for (int i = 0; i < 8 && q.size() != 0; i++) begin
         @(negedge clk); #1;
      end
      if (q.size() != 0) begin
         chk($sformatf("wb_timeout[%0d]", idx), 32'(q.size()), 32'd0);
         q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad   = 0;
      vt[0]  = mk(OP_RTYPE, 32'h10, 0, 5'd3, 1, 0, 0, 0, 0, 0, 0,
                  32'h10, 1, 1, 0, 0);
      vt[1]  = mk(OP_LW, 32'h100, 0, 5'd5, 1, 1, 3, 32'hDEAD_BEEF,
                  4'hF, 0, 0, 32'hDEAD_BEEF, 1, 1, 0, 0);
      vt[2]  = mk(OP_SW, 32'h102, 32'h55, 5'd0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 1, 0);
      vt[3]  = mk(OP_LW, 32'h200, 0, 5'd6, 1, 1, 0, 0, 4'hF, 0, 0,
                  0, 0, 0, 0, 1);
      vt[4]  = mk(OP_SW, 32'h304, 32'hCAFE_F00D, 5'd0, 0, 1, 1, 0,
                  4'hF, 1, 32'hCAFE_F00D, 0, 0, 0, 0, 0);
      vt[5]  = mk(OP_LW, 32'h40, 0, 5'd9, 1, 1, TMO, 32'h1234_5678,
                  4'hF, 0, 0, 32'h1234_5678, 1, 1, 0, 0);
      vt[6]  = mk(OP_LW, 32'h41, 0, 5'd9, 1, 0, 0, 0, 0, 0, 0,
                  0, 0, 0, 1, 0);
      vt[7]  = mk(OP_RTYPE, 32'hABCD, 0, 5'd2, 0, 0, 0, 0, 0, 0, 0,
                  32'hABCD, 1, 0, 0, 0);
      vt[8]  = mk(6'b001000, 32'hFFFF_FFFF, 0, 5'd31, 1, 0, 0, 0, 0, 0, 0,
                  32'hFFFF_FFFF, 1, 1, 0, 0);
`ifdef MEM_STAGE_BYTE_ACCESS_EN
      vt[9]  = mk(OP_LB, 32'h203, 0, 5'd7, 1, 1, 1, 32'h8011_2233,
                  4'hF, 0, 0, 32'hFFFF_FF80, 1, 1, 0, 0);
      vt[10] = mk(OP_LBU, 32'h201, 0, 5'd8, 1, 1, 2, 32'h0000_A500,
                  4'hF, 0, 0, 32'h0000_00A5, 1, 1, 0, 0);
      vt[11] = mk(OP_SB, 32'h202, 32'h1234_5677, 5'd0, 0, 1, 2, 0,
                  4'b0100, 1, 32'h7777_7777, 0, 0, 0, 0, 0);
`else
      vt[9]  = mk(OP_LB, 32'h203, 0, 5'd7, 1, 0, 0, 0, 0, 0, 0,
                  32'h203, 1, 0, 0, 0);
      vt[10] = mk(OP_LBU, 32'h201, 0, 5'd8, 1, 0, 0, 0, 0, 0, 0,
                  32'h201, 1, 0, 0, 0);
      vt[11] = mk(OP_SB, 32'h202, 32'h1234_5677, 5'd4, 1, 0, 0, 0, 0, 0, 0,
                  32'h202, 1, 0, 0, 0);
`endif
      vt[12] = mk(OP_SW, 32'h7FFC, 32'h0BAD_F00D, 5'd0, 0, 1, 2, 0,
                  4'hF, 1, 32'h0BAD_F00D, 0, 0, 0, 0, 0);
      vt[13] = mk(OP_LW, 32'h100, 0, 5'd12, 0, 1, 1, 32'h1,
                  4'hF, 0, 0, 32'h1, 1, 0, 0, 0);

      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.opcode     = '0;
      bus.alu_result = '0;
      bus.store_data = '0;
      bus.dest_reg   = '0;
      bus.reg_write  = 1'b0;
      bus.mem_ack    = 1'b0;
      bus.mem_rdata  = '0;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
      chk("rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("rst_mem_addr", bus.mem_addr, 32'd0);
      chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
      chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("rst_wb_we", 32'(bus.wb_we), 32'd0);
      chk("rst_wb_data", bus.wb_data, 32'd0);
      chk("rst_wb_reg", 32'(bus.wb_reg), 32'd0);
      chk("rst_exc_mis", 32'(bus.exc_misaligned), 32'd0);
      chk("rst_exc_bus", 32'(bus.exc_bus), 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 14; i++) run_vec(vt[i], i);

      // acks while idle must not start or complete anything
      @(posedge clk); #1;
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'hFFFF_FFFF;
      repeat (3) @(posedge clk);
      #1 bus.mem_ack = 1'b0;
      @(negedge clk);
      chk("stray_ack_in_ready", 32'(bus.in_ready), 32'd1);
      chk("stray_ack_mem_req", 32'(bus.mem_req), 32'd0);
      repeat (3) @(negedge clk);

      // reset in the middle of a load request
      @(posedge clk); #1;
      bus.in_valid   = 1'b1;
      bus.opcode     = OP_LW;
      bus.alu_result = 32'h100;
      bus.dest_reg   = 5'd4;
      bus.reg_write  = 1'b1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      chk("mid_rst_req_before", 32'(bus.mem_req), 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_mem_req", 32'(bus.mem_req), 32'd0);
      chk("mid_rst_mem_be", 32'(bus.mem_be), 32'd0);
      chk("mid_rst_wb_valid", 32'(bus.wb_valid), 32'd0);
      chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      bus.mem_ack = 1'b1;
      @(posedge clk); #1;
      bus.mem_ack = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("post_rst_mem_req", 32'(bus.mem_req), 32'd0);

      run_vec(vt[1], 100);
      run_vec(vt[0], 101);

      #20;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL set the maximum number of cycles to wait for mem_ack before a bus error is raised.
REQ-002 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  in  1  SHALL be the asynchronous, active-high reset.
REQ-004 in_valid  in  1  SHALL indicate the execute-stage result is valid.
REQ-005 in_ready  out  1  SHALL indicate that the stage accepts an operation this cycle.
REQ-006 opcode  in  6  SHALL carry the MIPS primary opcode of the operation.
REQ-007 alu_result  in  32  SHALL carry the ALU output, which is the effective address for loads and stores.
REQ-008 store_data  in  32  SHALL carry the rt register value for stores.
REQ-009 dest_reg  in  5  SHALL carry the destination register; reg_write  in  1  SHALL carry its write enable.
REQ-010 mem_req  out  1  SHALL be the data-memory request; mem_we  out  1  SHALL be its write strobe.
REQ-011 mem_addr  out  32  SHALL be the word-aligned address; mem_be  out  4  SHALL be the byte enables; mem_wdata  out  32  SHALL be the write data.
REQ-012 mem_ack  in  1  SHALL be the memory completion pulse; mem_rdata  in  32  SHALL be valid with mem_ack.
REQ-013 wb_valid  out  1  SHALL be a one-cycle result pulse; wb_data  out  32, wb_reg  out  5 and wb_we  out  1 SHALL accompany it.
REQ-014 exc_misaligned  out  1 and exc_bus  out  1 SHALL be exception flags that are valid only with wb_valid.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, REQ and RESP.
REQ-016 in_ready SHALL be 1 only in IDLE; an operation SHALL be accepted when in_valid and in_ready are both 1.
REQ-017 An accepted non-memory opcode SHALL produce wb_valid on the next cycle, with wb_data=alu_result and wb_we=reg_write, and the FSM SHALL stay in IDLE.
REQ-018 Accepted LW (100011) or SW (101011) with alu_result[1:0]=0 SHALL enter REQ, driving registered mem_req=1, mem_addr={alu_result[31:2],2'b00} and mem_be=4'b1111.
REQ-019 For stores, mem_we SHALL be 1 and mem_wdata=store_data; for loads, mem_we SHALL be 0.
REQ-020 In REQ, mem_req and all mem_* outputs SHALL be held stable until the first cycle in which mem_ack=1.
REQ-021 On mem_ack in REQ, mem_req SHALL drop next cycle and the FSM SHALL go to RESP, capturing mem_rdata.
REQ-022 In RESP, wb_valid=1 SHALL be driven for exactly one cycle before returning to IDLE; loads give wb_we=reg_write and wb_data=loaded value, stores give wb_we=0.
REQ-023 mem_ack outside REQ SHALL be ignored.
REQ-024 LW/SW with alu_result[1:0]!=0 SHALL issue no memory request; wb_valid, exc_misaligned=1 and wb_we=0 SHALL follow on the next cycle.
REQ-025 A cycle counter SHALL run in REQ; when it reaches TIMEOUT without mem_ack, mem_req SHALL drop and RESP SHALL pulse wb_valid with exc_bus=1 and wb_we=0.
REQ-026 A mem_ack arriving in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, no exc_bus.
REQ-027 Load latency SHALL be 1 cycle after mem_ack plus RESP (wb_valid two cycles after the ack edge); store latency SHALL be identical.

Reset
REQ-028 rst SHALL force IDLE immediately and clear the counter.
REQ-029 rst SHALL clear mem_req, mem_we, mem_be, wb_valid, wb_we, exc_misaligned and exc_bus to 0, and all data/address outputs to 0.
REQ-030 An operation in flight at reset SHALL be discarded with no wb_valid.

Configuration
REQ-031 Macro MEM_STAGE_BYTE_ACCESS_EN defined SHALL add LB (100000), LBU (100100) and SB (101000) with no alignment check.
REQ-032 Under the macro, SB SHALL use one-hot mem_be selected by addr[1:0] and replicate store_data[7:0] to all byte lanes; LB SHALL sign-extend the selected byte and LBU SHALL zero-extend it.
REQ-033 Without the macro, the LB, LBU and SB opcodes SHALL be handled as non-memory operations with wb_we forced to 0.

Structure
REQ-034 Shared package mips_pkg SHALL hold the opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_LB, OP_LBU, OP_SB) and the FSM state enum.
REQ-035 Sub-module mem_load_align SHALL perform combinational byte/word selection and extension of mem_rdata given addr[1:0] and opcode.

Verification
REQ-036 R-type, alu_result=0x0000_0010 -> wb_valid next cycle, wb_data=0x10, no mem_req.
REQ-037 LW addr 0x100, mem_ack after 3 cycles with rdata 0xDEADBEEF -> mem_req held 3 cycles, wb_data=0xDEADBEEF, wb_we=1.
REQ-038 SW addr 0x102 -> no mem_req, exc_misaligned=1, wb_we=0.
REQ-039 LW with no mem_ack, TIMEOUT=4 -> mem_req drops after 4 cycles, exc_bus=1.
REQ-040 rst asserted mid-REQ -> mem_req=0 asynchronously, no wb_valid, in_ready=1 after release.
REQ-041 With the macro defined, LB at addr 0x203 with rdata 0x80xx_xxxx -> wb_data=0xFFFF_FF80.
